// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package instr_fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2,
        ST_ERR  = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
    localparam int unsigned OPCODE_MSB        = 31;
    localparam int unsigned OPCODE_LSB        = 26;
    localparam logic [31:0] WORD_BYTES        = 32'd4;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_timer.sv
// Wait-state counter for an outstanding fetch; flags the cycle whose increment reaches TIMEOUT.
module ifetch_timer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int unsigned W = $clog2(TIMEOUT + 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Expiry is a function of registered count only, so it never loops back through clear_i.
    assign expire_o = en_i && (count_q == W'(TIMEOUT - 1));

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, req/ack instruction-memory handshake, one registered output slot.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned TIMEOUT   = 16,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] instr_o,
    output logic [5:0]  instr_op_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic        instr_valid_o,
    output logic        misalign_o,
    output logic        fetch_err_o
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  addr_q, addr_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  pc_out_q, pc_out_d;
    logic         req_q, req_d;
    logic         valid_q, valid_d;
    logic         kill_q, kill_d;
    logic         misalign_q, misalign_d;
    logic         err_q, err_d;
    logic         timer_expire;

    ifetch_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (state_d != ST_WAIT),
        .en_i     (state_q == ST_WAIT),
        .expire_o (timer_expire)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        addr_d     = addr_q;
        instr_d    = instr_q;
        pc_out_d   = pc_out_q;
        req_d      = req_q;
        valid_d    = valid_q;
        kill_d     = kill_q;
        misalign_d = 1'b0;
        err_d      = err_q;

        // A live instruction leaves the slot whenever downstream is not stalling.
        if (valid_q && !stall_i) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
        end

        case (state_q)
            ST_REQ: begin
                if (!valid_q || !stall_i) begin
                    req_d   = 1'b1;
                    addr_d  = pc_q;
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_WAIT: begin
                if (imem_ack_i) begin
                    req_d   = 1'b0;
                    state_d = ST_REQ;
                    if (kill_q) begin
                        kill_d = 1'b0;
                    end else begin
                        instr_d  = imem_rdata_i;
                        pc_out_d = pc_q;
                        valid_d  = 1'b1;
                        pc_d     = pc_q + WORD_BYTES;
                    end
                end else if (timer_expire) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    valid_d = 1'b0;
                    instr_d = NOP_INSTR;
                    state_d = ST_ERR;
                end
            end
            ST_HOLD: begin
                if (!stall_i) begin
                    state_d = ST_REQ;
                end
            end
            ST_ERR: begin
                req_d   = 1'b0;
                valid_d = 1'b0;
                instr_d = NOP_INSTR;
            end
            default: begin
                state_d = ST_REQ;
            end
        endcase

        // Redirect overrides everything; an unacked request stays open and its data is dropped later.
        if (redirect_i && (state_q != ST_ERR)) begin
            pc_d       = align_word(redirect_pc_i);
            valid_d    = 1'b0;
            instr_d    = NOP_INSTR;
            misalign_d = |redirect_pc_i[1:0];
            err_d      = err_q;
            if ((state_q == ST_WAIT) && !imem_ack_i) begin
                kill_d  = 1'b1;
                req_d   = 1'b1;
                state_d = ST_WAIT;
            end else begin
                kill_d  = 1'b0;
                req_d   = 1'b0;
                state_d = ST_REQ;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q    <= ST_REQ;
            pc_q       <= RESET_PC;
            addr_q     <= RESET_PC;
            instr_q    <= NOP_INSTR;
            pc_out_q   <= RESET_PC;
            req_q      <= 1'b0;
            valid_q    <= 1'b0;
            kill_q     <= 1'b0;
            misalign_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            instr_q    <= instr_d;
            pc_out_q   <= pc_out_d;
            req_q      <= req_d;
            valid_q    <= valid_d;
            kill_q     <= kill_d;
            misalign_q <= misalign_d;
            err_q      <= err_d;
        end
    end

    assign imem_req_o    = req_q;
    assign imem_addr_o   = addr_q;
    assign instr_o       = instr_q;
    assign instr_op_o    = instr_q[OPCODE_MSB:OPCODE_LSB];
    assign pc_o          = pc_out_q;
    assign pc_plus4_o    = pc_out_q + WORD_BYTES;
    assign instr_valid_o = valid_q;
    assign misalign_o    = misalign_q;
    assign fetch_err_o   = err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: cycle table for streaming/stall, hand sequences for corners.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        auto_ack;
    logic        man_ack;
    logic [31:0] man_rdata;

    logic        req, ack, valid, misalign, err;
    logic [31:0] addr, rdata, instr, pc, pc_plus4;
    logic [5:0]  op;

    logic        req2, ack2, valid2, misalign2, err2;
    logic [31:0] addr2, rdata2, instr2, pc2, pc_plus4_2;
    logic [5:0]  op2;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] NOP = 32'h0000_0000;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[7:2] ^ 6'h2A, a[25:0]};
    endfunction

    assign ack   = auto_ack ? req : man_ack;
    assign rdata = auto_ack ? mem_word(addr) : man_rdata;
    assign ack2   = req2;
    assign rdata2 = mem_word(addr2);

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(16)) u_dut (
        .clk_i(clk), .rst_i(rst),
        .imem_req_o(req), .imem_addr_o(addr), .imem_ack_i(ack), .imem_rdata_i(rdata),
        .stall_i(stall), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .instr_o(instr), .instr_op_o(op), .pc_o(pc), .pc_plus4_o(pc_plus4),
        .instr_valid_o(valid), .misalign_o(misalign), .fetch_err_o(err)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .TIMEOUT(16)) u_dut_wrap (
        .clk_i(clk), .rst_i(rst),
        .imem_req_o(req2), .imem_addr_o(addr2), .imem_ack_i(ack2), .imem_rdata_i(rdata2),
        .stall_i(1'b0), .redirect_i(1'b0), .redirect_pc_i(32'h0),
        .instr_o(instr2), .instr_op_o(op2), .pc_o(pc2), .pc_plus4_o(pc_plus4_2),
        .instr_valid_o(valid2), .misalign_o(misalign2), .fetch_err_o(err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Leaves the bench at the negedge of the first cycle after reset, with reset released.
    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_req"},      {31'b0, req},      32'd0);
        chk({tag, "_addr"},     addr,              32'h0);
        chk({tag, "_instr"},    instr,             NOP);
        chk({tag, "_op"},       {26'b0, op},       32'd0);
        chk({tag, "_pc"},       pc,                32'h0);
        chk({tag, "_pc4"},      pc_plus4,          32'h4);
        chk({tag, "_valid"},    {31'b0, valid},    32'd0);
        chk({tag, "_misalign"}, {31'b0, misalign}, 32'd0);
        chk({tag, "_err"},      {31'b0, err},      32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] exp_instr;
        rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        auto_ack = 1'b1; man_ack = 1'b0; man_rdata = 32'h0;

        // cycle-by-cycle expectations with zero-wait memory; stall held for 5 cycles from c6
        vecs[0]  = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 1'b1, 32'h0, 1'b0, 32'h0};
        vecs[2]  = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h0};
        vecs[3]  = '{1'b0, 1'b1, 32'h4, 1'b0, 32'h0};
        vecs[4]  = '{1'b0, 1'b0, 32'h4, 1'b1, 32'h4};
        vecs[5]  = '{1'b0, 1'b1, 32'h8, 1'b0, 32'h0};
        vecs[6]  = '{1'b1, 1'b0, 32'h8, 1'b1, 32'h8};
        vecs[7]  = '{1'b1, 1'b0, 32'h8, 1'b1, 32'h8};
        vecs[8]  = '{1'b1, 1'b0, 32'h8, 1'b1, 32'h8};
        vecs[9]  = '{1'b1, 1'b0, 32'h8, 1'b1, 32'h8};
        vecs[10] = '{1'b1, 1'b0, 32'h8, 1'b1, 32'h8};
        vecs[11] = '{1'b0, 1'b0, 32'h8, 1'b1, 32'h8};
        vecs[12] = '{1'b0, 1'b0, 32'h8, 1'b0, 32'h0};
        vecs[13] = '{1'b0, 1'b1, 32'hC, 1'b0, 32'h0};
        vecs[14] = '{1'b0, 1'b0, 32'hC, 1'b1, 32'hC};

        do_reset();
        chk_reset_values("reset");
        chk("wrap_reset_pc",  pc2,        32'hFFFF_FFFC);
        chk("wrap_reset_pc4", pc_plus4_2, 32'h0);
        $display("reset: checked reset values");

        for (int i = 0; i < 15; i++) begin
            if (i > 0) @(negedge clk);
            stall = vecs[i].stall;
            exp_instr = vecs[i].valid ? mem_word(vecs[i].pc) : NOP;
            chk($sformatf("vec%0d_req", i), {31'b0, req}, {31'b0, vecs[i].req});
            if (vecs[i].req) chk($sformatf("vec%0d_addr", i), addr, vecs[i].addr);
            chk($sformatf("vec%0d_valid", i), {31'b0, valid}, {31'b0, vecs[i].valid});
            chk($sformatf("vec%0d_instr", i), instr, exp_instr);
            chk($sformatf("vec%0d_op", i), {26'b0, op}, {26'b0, exp_instr[31:26]});
            if (vecs[i].valid) begin
                chk($sformatf("vec%0d_pc", i), pc, vecs[i].pc);
                chk($sformatf("vec%0d_pc4", i), pc_plus4, vecs[i].pc + 32'd4);
            end
            if (i == 1) chk("wrap_addr0", addr2, 32'hFFFF_FFFC);
            if (i == 2) chk("wrap_pc4",   pc_plus4_2, 32'h0);
            if (i == 3) chk("wrap_addr1", addr2, 32'h0);
            $display("vec %0d: stall=%0b req=%0b addr=%h valid=%0b pc=%h instr=%h",
                     i, stall, req, addr, valid, pc, instr);
        end
        stall = 1'b0;

        // 3 wait states: request held 4 cycles, ack on the 4th
        auto_ack = 1'b0;
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk($sformatf("wait_req_c%0d", k), {31'b0, req}, 32'd1);
            chk($sformatf("wait_addr_c%0d", k), addr, 32'h0);
            if (k == 4) begin
                man_ack = 1'b1;
                man_rdata = 32'h8C22_0004;
            end
        end
        @(negedge clk);
        man_ack = 1'b0;
        chk("wait_valid", {31'b0, valid}, 32'd1);
        chk("wait_instr", instr, 32'h8C22_0004);
        chk("wait_op", {26'b0, op}, 32'h23);
        chk("wait_pc", pc, 32'h0);
        chk("wait_req_low", {31'b0, req}, 32'd0);
        $display("wait3: instr=%h op=%h", instr, op);

        // redirect while waiting: late data dropped, fetch restarts at target
        do_reset();
        @(negedge clk);
        chk("redir_req", {31'b0, req}, 32'd1);
        redirect = 1'b1; redirect_pc = 32'h0000_0040;
        @(negedge clk);
        redirect = 1'b0;
        chk("redir_req_held", {31'b0, req}, 32'd1);
        chk("redir_addr_held", addr, 32'h0);
        chk("redir_valid", {31'b0, valid}, 32'd0);
        chk("redir_instr", instr, NOP);
        @(negedge clk);
        man_ack = 1'b1; man_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        man_ack = 1'b0;
        chk("redir_drop_valid", {31'b0, valid}, 32'd0);
        chk("redir_drop_instr", instr, NOP);
        chk("redir_drop_req", {31'b0, req}, 32'd0);
        @(negedge clk);
        chk("redir_new_req", {31'b0, req}, 32'd1);
        chk("redir_new_addr", addr, 32'h0000_0040);
        man_ack = 1'b1; man_rdata = 32'h1234_5678;
        @(negedge clk);
        man_ack = 1'b0;
        chk("redir_new_valid", {31'b0, valid}, 32'd1);
        chk("redir_new_instr", instr, 32'h1234_5678);
        chk("redir_new_pc", pc, 32'h0000_0040);
        chk("redir_new_op", {26'b0, op}, 32'h04);
        $display("redirect: refetched %h at %h", instr, pc);

        // misaligned redirect target
        redirect = 1'b1; redirect_pc = 32'h0000_0042;
        @(negedge clk);
        redirect = 1'b0;
        chk("mis_pulse", {31'b0, misalign}, 32'd1);
        chk("mis_valid", {31'b0, valid}, 32'd0);
        chk("mis_req", {31'b0, req}, 32'd0);
        @(negedge clk);
        chk("mis_pulse_end", {31'b0, misalign}, 32'd0);
        chk("mis_req2", {31'b0, req}, 32'd1);
        chk("mis_addr", addr, 32'h0000_0040);
        $display("misalign: fetch addr=%h", addr);

        // ack never arrives: error after 16 wait cycles, sticky through redirect
        do_reset();
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            chk($sformatf("to_req_c%0d", k), {31'b0, req}, 32'd1);
            if (k == 16) chk("to_err_early", {31'b0, err}, 32'd0);
        end
        @(negedge clk);
        chk("to_err", {31'b0, err}, 32'd1);
        chk("to_req_low", {31'b0, req}, 32'd0);
        chk("to_valid", {31'b0, valid}, 32'd0);
        redirect = 1'b1; redirect_pc = 32'h0000_0082;
        @(negedge clk);
        redirect = 1'b0;
        chk("err_redir_mis", {31'b0, misalign}, 32'd0);
        repeat (2) @(negedge clk);
        chk("err_sticky", {31'b0, err}, 32'd1);
        chk("err_req", {31'b0, req}, 32'd0);
        chk("err_instr", instr, NOP);
        $display("timeout: err=%0b req=%0b", err, req);
        do_reset();
        chk("err_cleared", {31'b0, err}, 32'd0);

        // reset in the middle of a wait; a late ack must be ignored
        @(negedge clk);
        chk("mid_req", {31'b0, req}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        man_ack = 1'b1; man_rdata = 32'hAAAA_5555;
        chk_reset_values("midrst");
        @(negedge clk);
        man_ack = 1'b0;
        chk("midrst_req", {31'b0, req}, 32'd1);
        chk("midrst_valid", {31'b0, valid}, 32'd0);
        @(negedge clk);
        chk("midrst_valid2", {31'b0, valid}, 32'd0);
        chk("midrst_instr", instr, NOP);
        $display("midreset: req=%0b valid=%0b", req, valid);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
